axis_sram_streamer: RTL and testbench
=====================================

Name: axis_sram_streamer

Overview:
Parametrised successor to the NPU output streamer: reads a result buffer from output SRAM and emits it on an AXI4-Stream master port with full backpressure support. Supports configurable SRAM read latency, a base address, and element packing of up to MAX_GROUPS elements per SRAM word. A credit-limited prefetch FIFO absorbs in-flight reads, so no data is lost or duplicated while tready is low. Sits between the output SRAM and the DMA/stream interconnect.

Parameters:
SRAM_WIDTH_O, 64, SRAM word and tdata width in bits
DATA_WIDTH, 8, element width in bits
MAX_GROUPS, SRAM_WIDTH_O/DATA_WIDTH, maximum elements per word
MAX_ADDR_WIDTH, 13, SRAM address width
SIZE_WIDTH, 16, element-count width
READ_LATENCY, 1, SRAM cycles from en to data (1..4)
FIFO_DEPTH, 4, prefetch FIFO entries; must be ≥ READ_LATENCY+2 (elaboration check)

Ports:
m_axis_aclk  in  1  clock
m_axis_areset  in  1  synchronous reset, active-high
start  in  1  one-cycle start pulse
base_addr  in  MAX_ADDR_WIDTH  first SRAM word address
out_size  in  SIZE_WIDTH  total elements to send
groups  in  clog2(MAX_GROUPS+1)  elements per SRAM word
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after final beat handshake
sram_out_en  out  1  SRAM read enable
sram_out_addr  out  MAX_ADDR_WIDTH  SRAM read address
sram_out_data_out  in  SRAM_WIDTH_O  SRAM read data
m_axis_tdata  out  SRAM_WIDTH_O  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  final beat
m_axis_tuser  out  clog2(MAX_GROUPS+1)  valid element count in beat

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO, counters and in-flight tracking cleared. Reset mid-operation aborts the transfer; SRAM data still in flight is discarded, and there is no done pulse.
- FSM: IDLE -> RUN on start. RUN -> DRAIN when all words are issued. DRAIN -> DONE when the last beat handshakes. DONE -> IDLE after 1 cycle, with done=1 during DONE. start is ignored outside IDLE.
- On start, capture base_addr, out_size and groups. groups=0 is treated as 1; groups>MAX_GROUPS is clamped. out_size=0 goes directly to DONE with no beats.
- num_words = ceil(out_size/groups). Compute with an accumulating element counter (+groups per issue); no divider.
- Issue rule: sram_out_en=1 in RUN when words remain and fifo_count+inflight < FIFO_DEPTH. Address = base_addr + word_idx, modulo 2^MAX_ADDR_WIDTH (wraps). When sram_out_en=0, sram_out_addr holds its value.
- Return path: a READ_LATENCY-deep shift register of valid/last/count tags accompanies each read. Data is pushed into the FIFO on the edge ending cycle t+READ_LATENCY.
- Latency: start in cycle 0; first read in cycle 1; first tvalid in cycle 2+READ_LATENCY.
- Output: FIFO is first-word-fall-through. tvalid = !empty. Pop on tvalid&&tready. tdata/tlast/tuser are stable while tvalid&&!tready. When tvalid=0 they are driven 0.
- Throughput: with tready held high, 1 beat/cycle sustained, with no bubbles after the first beat.
- tuser = groups for full words. On the last word, tuser = out_size − groups·(num_words−1).
- tlast=1 only on beat num_words−1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged. The credit rule guarantees no overflow.
- busy=1 in RUN, DRAIN and DONE.

Decomposition:
- Shared package npu_stream_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE), a clog2 helper, and a width-check macro for FIFO_DEPTH ≥ READ_LATENCY+2.
- One sub-module: axis_fwft_fifo, parametrised on width and depth, payload {last, user, data}, exposing count. The top level holds the FSM, counters, credit logic and latency tag pipe.

Test Plan:
- out_size=48, groups=8, base=0x10, tready=1, READ_LATENCY=1 -> 6 beats in cycles 3..8 with addresses 0x10..0x15; tuser=8 on all beats; tlast on beat 6; done in cycle 9.
- out_size=50, groups=8 -> 7 beats; last beat tuser=2 with tlast.
- Same as first, tready random 50% -> data order 0x10..0x15 preserved; no drop or duplicate; tdata stable during stalls; FIFO never exceeds 4.
- READ_LATENCY=3, FIFO_DEPTH=5, tready held 0 for 20 cycles -> at most 5 reads issued, then sram_out_en=0 until pops.
- out_size=0 -> no tvalid; done one cycle after start. groups=0 with out_size=3 -> 3 beats with tuser=1.
- Reset asserted after 2 of 6 beats -> outputs 0 next cycle; a new start afterwards completes a clean 6-beat transfer; base_addr=0x1FFE spans 0x1FFE, 0x1FFF, 0x0000.

Source files
------------

// File: rtl/npu_stream_pkg.sv
// rtl/npu_stream_pkg.sv - shared types and helpers for the NPU stream blocks
`ifndef NPU_STREAM_PKG_SV
`define NPU_STREAM_PKG_SV

// Elaboration guard: the prefetch FIFO must hold every in-flight read plus
// one entry of slack so back-to-back issue never overruns it.
`define NPU_STREAM_DEPTH_CHECK(depth, latency) \
  if ((depth) < (latency) + 2) begin : g_fifo_depth_check \
    $error("FIFO_DEPTH must be at least READ_LATENCY+2"); \
  end

package npu_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stream_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`endif

// File: rtl/axis_sram_streamer_if.sv
// rtl/axis_sram_streamer_if.sv - SRAM read port and AXI4-Stream master bundle
interface axis_sram_streamer_if #(
  parameter int SRAM_WIDTH_O   = 64,
  parameter int MAX_ADDR_WIDTH = 13,
  parameter int USER_WIDTH     = 4
);
  logic                      sram_out_en;
  logic [MAX_ADDR_WIDTH-1:0] sram_out_addr;
  logic [SRAM_WIDTH_O-1:0]   sram_out_data_out;

  logic [SRAM_WIDTH_O-1:0]   m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;
  logic [USER_WIDTH-1:0]     m_axis_tuser;

  modport master (
    output sram_out_en, sram_out_addr,
    input  sram_out_data_out,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    input  sram_out_en, sram_out_addr,
    output sram_out_data_out,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_fwft_fifo.sv
// rtl/axis_fwft_fifo.sv - first-word-fall-through FIFO with occupancy output
module axis_fwft_fifo
  import npu_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int COUNT_WIDTH = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_tdata,
  input  logic                   s_tvalid,
  output logic [WIDTH-1:0]       m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [COUNT_WIDTH-1:0] count
);
  localparam int PTR_WIDTH = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   full, push, pop;

  assign full = (count_q == COUNT_WIDTH'(DEPTH));
  assign pop  = m_tvalid && m_tready;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign push = s_tvalid && (!full || pop);

  // Payload storage; entries are only visible through count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_tdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_tdata  = mem[rd_ptr_q];
  assign m_tvalid = (count_q != '0);
  assign count    = count_q;
endmodule

// File: rtl/axis_sram_streamer.sv
// rtl/axis_sram_streamer.sv - streams a packed SRAM result buffer onto AXI4-Stream
module axis_sram_streamer
  import npu_stream_pkg::*;
#(
  parameter int SRAM_WIDTH_O   = 64,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_GROUPS     = SRAM_WIDTH_O / DATA_WIDTH,
  parameter int MAX_ADDR_WIDTH = 13,
  parameter int SIZE_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter int FIFO_DEPTH     = 4,
  localparam int GROUP_WIDTH   = clog2(MAX_GROUPS + 1)
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_areset,
  input  logic                      start,
  input  logic [MAX_ADDR_WIDTH-1:0] base_addr,
  input  logic [SIZE_WIDTH-1:0]     out_size,
  input  logic [GROUP_WIDTH-1:0]    groups,
  output logic                      busy,
  output logic                      done,
  axis_sram_streamer_if.master      bus
);
  localparam int CNT_W     = clog2(FIFO_DEPTH + 1);
  localparam int ELEM_W    = SIZE_WIDTH + 1;
  localparam int PAYLOAD_W = 1 + GROUP_WIDTH + SRAM_WIDTH_O;

  `NPU_STREAM_DEPTH_CHECK(FIFO_DEPTH, READ_LATENCY)

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_latency_check
    $error("READ_LATENCY must be in 1..4");
  end

  stream_state_e state_q, state_d;

  logic [SIZE_WIDTH-1:0]     size_q;
  logic [GROUP_WIDTH-1:0]    groups_q, groups_eff;
  logic [ELEM_W-1:0]         issued_q;      // elements covered by words already read
  logic [ELEM_W-1:0]         issued_next, remaining;
  logic [MAX_ADDR_WIDTH-1:0] next_addr_q, last_addr_q;
  logic [CNT_W-1:0]          inflight_q, fifo_count;
  logic                      words_left, credit_ok, issue, issue_last;
  logic [GROUP_WIDTH-1:0]    issue_count;

  logic [READ_LATENCY-1:0]   tag_valid_q, tag_last_q;
  logic [GROUP_WIDTH-1:0]    tag_count_q [READ_LATENCY];
  logic                      ret_valid;

  logic [PAYLOAD_W-1:0]      fifo_in, fifo_out;
  logic                      fifo_valid, pop;
  logic                      out_last;
  logic [GROUP_WIDTH-1:0]    out_user;
  logic [SRAM_WIDTH_O-1:0]   out_data;

  assign groups_eff = (groups == '0) ? GROUP_WIDTH'(1) :
                      (groups > GROUP_WIDTH'(MAX_GROUPS)) ? GROUP_WIDTH'(MAX_GROUPS) : groups;

  // Issue decision: a read goes out only while the FIFO can absorb everything in flight.
  always_comb begin
    issued_next = issued_q + ELEM_W'(groups_q);
    remaining   = ELEM_W'(size_q) - issued_q;
    words_left  = (ELEM_W'(size_q) > issued_q);
    credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    issue       = (state_q == RUN) && words_left && credit_ok;
    issue_last  = (issued_next >= ELEM_W'(size_q));
    issue_count = issue_last ? GROUP_WIDTH'(remaining) : groups_q;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (out_size == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, command capture, word counters and read credit tracking.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      groups_q    <= '0;
      issued_q    <= '0;
      next_addr_q <= '0;
      last_addr_q <= '0;
      inflight_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        size_q      <= out_size;
        groups_q    <= groups_eff;
        issued_q    <= '0;
        next_addr_q <= base_addr;
      end
      if (issue) begin
        issued_q    <= issued_next;
        next_addr_q <= next_addr_q + 1'b1;
        last_addr_q <= next_addr_q;
      end
      case ({issue, ret_valid})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Tag pipe travelling alongside each SRAM read so data and sideband land together.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_count_q[i] <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
        tag_count_q[i] <= tag_count_q[i-1];
      end
      tag_valid_q[0] <= issue;
      tag_last_q[0]  <= issue && issue_last;
      tag_count_q[0] <= issue_count;
    end
  end

  assign ret_valid = tag_valid_q[READ_LATENCY-1];
  assign fifo_in   = {tag_last_q[READ_LATENCY-1], tag_count_q[READ_LATENCY-1], bus.sram_out_data_out};

  axis_fwft_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (m_axis_aclk),
    .rst      (m_axis_areset),
    .s_tdata  (fifo_in),
    .s_tvalid (ret_valid),
    .m_tdata  (fifo_out),
    .m_tvalid (fifo_valid),
    .m_tready (bus.m_axis_tready),
    .count    (fifo_count)
  );

  assign {out_last, out_user, out_data} = fifo_out;
  assign pop = fifo_valid && bus.m_axis_tready;

  assign bus.sram_out_en   = issue;
  assign bus.sram_out_addr = issue ? next_addr_q : last_addr_q;
  assign bus.m_axis_tvalid = fifo_valid;
  assign bus.m_axis_tdata  = fifo_valid ? out_data : '0;
  assign bus.m_axis_tuser  = fifo_valid ? out_user : '0;
  assign bus.m_axis_tlast  = fifo_valid && out_last;
endmodule

// File: tb/tb_axis_sram_streamer.sv
// tb/tb_axis_sram_streamer.sv - scoreboard bench for axis_sram_streamer
module tb_axis_sram_streamer;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int SW = 16;
  localparam int GW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [GW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {16'hD00D, 3'b000, a, 16'hBEEF, ~{3'b000, a}};
  endfunction

  // DUT A: READ_LATENCY=1, FIFO_DEPTH=4
  logic          start_a = 1'b0;
  logic [AW-1:0] base_a = '0;
  logic [SW-1:0] size_a = '0;
  logic [GW-1:0] groups_a = '0;
  logic          busy_a, done_a;
  logic          tready_a = 1'b1;
  int            tready_mode = 0;
  logic [DW-1:0] sram_a_q = '0;

  axis_sram_streamer_if #(.SRAM_WIDTH_O(DW), .MAX_ADDR_WIDTH(AW), .USER_WIDTH(GW)) bus_a ();
  assign bus_a.m_axis_tready     = tready_a;
  assign bus_a.sram_out_data_out = sram_a_q;
  always @(posedge clk) if (bus_a.sram_out_en) sram_a_q <= word_of(bus_a.sram_out_addr);

  axis_sram_streamer #(.READ_LATENCY(1), .FIFO_DEPTH(4)) dut_a (
    .m_axis_aclk(clk), .m_axis_areset(rst), .start(start_a), .base_addr(base_a),
    .out_size(size_a), .groups(groups_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  // DUT B: READ_LATENCY=3, FIFO_DEPTH=5
  logic          start_b = 1'b0;
  logic [AW-1:0] base_b = '0;
  logic [SW-1:0] size_b = '0;
  logic [GW-1:0] groups_b = '0;
  logic          busy_b, done_b;
  logic          tready_b = 1'b0;
  logic [DW-1:0] sram_b_q [3];

  axis_sram_streamer_if #(.SRAM_WIDTH_O(DW), .MAX_ADDR_WIDTH(AW), .USER_WIDTH(GW)) bus_b ();
  assign bus_b.m_axis_tready     = tready_b;
  assign bus_b.sram_out_data_out = sram_b_q[2];
  always @(posedge clk) begin
    sram_b_q[0] <= bus_b.sram_out_en ? word_of(bus_b.sram_out_addr) : '0;
    sram_b_q[1] <= sram_b_q[0];
    sram_b_q[2] <= sram_b_q[1];
  end

  axis_sram_streamer #(.READ_LATENCY(3), .FIFO_DEPTH(5)) dut_b (
    .m_axis_aclk(clk), .m_axis_areset(rst), .start(start_b), .base_addr(base_b),
    .out_size(size_b), .groups(groups_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready_a = (tready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  beat_t         exp_q[$];
  int            beats_a = 0, issued_a = 0, popped_a = 0, done_pulses = 0;
  int            start_cyc = 0, first_beat_cyc = -1, done_cyc = -1;
  logic          stall_a = 1'b0;
  logic [DW-1:0] stall_data_a = '0;
  logic [AW-1:0] last_addr_a = '0;
  int            issued_b = 0, beats_b = 0, done_b_seen = 0;
  logic [AW-1:0] exp_base_b = '0;

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.sram_out_en) begin
        issued_a++;
        check_eq("a_credit", 64'((issued_a - popped_a) <= 4), 64'd1);
        last_addr_a = bus_a.sram_out_addr;
      end else begin
        check_eq("a_addr_hold", 64'(bus_a.sram_out_addr), 64'(last_addr_a));
      end
      if (stall_a) begin
        check_eq("a_stall_tvalid", 64'(bus_a.m_axis_tvalid), 64'd1);
        check_eq("a_stall_tdata", bus_a.m_axis_tdata, stall_data_a);
      end
      stall_a      = bus_a.m_axis_tvalid && !bus_a.m_axis_tready;
      stall_data_a = bus_a.m_axis_tdata;
      if (!bus_a.m_axis_tvalid)
        check_eq("a_idle_zero", 64'((bus_a.m_axis_tdata != '0) || (bus_a.m_axis_tuser != '0) || bus_a.m_axis_tlast), 64'd0);
      if (bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
        popped_a++;
        if (beats_a == 0) first_beat_cyc = cyc - start_cyc;
        beats_a++;
        if (exp_q.size() == 0) begin
          check_eq("a_extra_beat", 64'd1, 64'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check_eq("a_tdata", bus_a.m_axis_tdata, b.data);
          check_eq("a_tuser", 64'(bus_a.m_axis_tuser), 64'(b.user));
          check_eq("a_tlast", 64'(bus_a.m_axis_tlast), 64'(b.last));
        end
      end
      if (done_a) begin
        done_pulses++;
        done_cyc = cyc - start_cyc;
        check_eq("a_busy_in_done", 64'(busy_a), 64'd1);
      end
      if (bus_b.sram_out_en) issued_b++;
      if (bus_b.m_axis_tvalid && bus_b.m_axis_tready) begin
        check_eq("b_tdata", bus_b.m_axis_tdata, word_of(AW'(exp_base_b + AW'(beats_b))));
        check_eq("b_tlast", 64'(bus_b.m_axis_tlast), 64'(beats_b == 9));
        beats_b++;
      end
      if (done_b) done_b_seen++;
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    issued_a = 0; popped_a = 0; last_addr_a = '0; stall_a = 1'b0; issued_b = 0;
    check_eq("rst_tvalid", 64'(bus_a.m_axis_tvalid), 64'd0);
    check_eq("rst_tdata", bus_a.m_axis_tdata, 64'd0);
    check_eq("rst_tlast_tuser", 64'({bus_a.m_axis_tlast, bus_a.m_axis_tuser}), 64'd0);
    check_eq("rst_sram", 64'({bus_a.sram_out_en, bus_a.sram_out_addr}), 64'd0);
    check_eq("rst_busy_done", 64'({busy_a, done_a, busy_b, done_b}), 64'd0);
  endtask

  // Loads the scoreboard for one transfer, starts it, and waits for done.
  task automatic run_a(input logic [AW-1:0] base, input int size, input int grp,
                       input int exp_first, input int exp_done, input bit glitch);
    int g, nw, d0;
    g  = (grp == 0) ? 1 : ((grp > 8) ? 8 : grp);
    nw = (size + g - 1) / g;
    for (int i = 0; i < nw; i++) begin
      beat_t b;
      b.data = word_of(AW'(base + AW'(i)));
      b.user = GW'((i == nw - 1) ? (size - g * (nw - 1)) : g);
      b.last = (i == nw - 1);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    start_a = 1'b1; base_a = base; size_a = SW'(size); groups_a = GW'(grp);
    start_cyc = cyc; beats_a = 0; first_beat_cyc = -1; d0 = done_pulses;
    @(posedge clk); #1;
    start_a = 1'b0; base_a = AW'($urandom); size_a = SW'($urandom); groups_a = GW'($urandom);
    check_eq("busy_after_start", 64'(busy_a), 64'd1);
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1 start_a = 1'b1; base_a = 13'h0777; size_a = 16'd5; groups_a = 4'd1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    for (int k = 0; k < 2000 && done_pulses == d0; k++) @(posedge clk);
    check_eq("done_seen", 64'(done_pulses - d0), 64'd1);
    @(posedge clk); #1;
    check_eq("busy_after_done", 64'(busy_a), 64'd0);
    check_eq("beat_count", 64'(beats_a), 64'(nw));
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    if (exp_first >= 0) check_eq("first_beat_cycle", 64'(first_beat_cyc), 64'(exp_first));
    if (exp_done >= 0) check_eq("done_cycle", 64'(done_cyc), 64'(exp_done));
  endtask

  initial begin
    int d0;
    reset_dut();

    run_a(13'h0010, 48, 8, 3, 9, 1'b0);
    run_a(13'h0010, 50, 8, 3, 10, 1'b0);
    run_a(13'h0020, 0, 8, -1, 1, 1'b0);
    run_a(13'h0030, 3, 0, 3, 6, 1'b0);
    run_a(13'h0040, 20, 12, 3, 6, 1'b0);

    tready_mode = 1;
    run_a(13'h0010, 48, 8, -1, -1, 1'b1);
    run_a(13'h0100, 100, 5, -1, -1, 1'b0);
    tready_mode = 0;

    for (int i = 0; i < 6; i++) begin
      beat_t b;
      b.data = word_of(AW'(13'h0200 + i)); b.user = 4'd8; b.last = (i == 5);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    start_a = 1'b1; base_a = 13'h0200; size_a = 16'd48; groups_a = 4'd8; beats_a = 0;
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 0; k < 200 && beats_a < 2; k++) @(posedge clk);
    check_eq("rst_two_beats", 64'(beats_a >= 2), 64'd1);
    d0 = done_pulses;
    reset_dut();
    repeat (10) @(posedge clk);
    check_eq("no_done_after_abort", 64'(done_pulses), 64'(d0));
    check_eq("no_beats_after_abort", 64'(issued_a), 64'd0);

    run_a(13'h1FFE, 48, 8, 3, 9, 1'b0);

    exp_base_b = 13'h0040; beats_b = 0; issued_b = 0; tready_b = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 13'h0040; size_b = 16'd80; groups_b = 4'd8;
    @(posedge clk); #1 start_b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("b_reads_while_stalled", 64'(issued_b), 64'd5);
    check_eq("b_en_stalled", 64'(bus_b.sram_out_en), 64'd0);
    check_eq("b_tvalid_stalled", 64'(bus_b.m_axis_tvalid), 64'd1);
    tready_b = 1'b1;
    for (int k = 0; k < 500 && done_b_seen == 0; k++) @(posedge clk);
    check_eq("b_done_seen", 64'(done_b_seen), 64'd1);
    check_eq("b_beat_count", 64'(beats_b), 64'd10);
    check_eq("b_read_count", 64'(issued_b), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
